// File: rtl/ad5761_spi_responder.sv
// ============================================================================
// Module   : ad5761_spi_responder
// Summary  : Oversampled SPI slave emulating the AD5761R DAC register interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad5761_spi_responder #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DAC_SCLK,
  input  logic        DAC_CS_N,
  input  logic        DAC_DIN,
  output logic        DAC_DOUT,
  output logic [23:0] rx_frame,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] dac_code,
  output logic [10:0] ctrl_reg,
  output logic [15:0] input_reg
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, din_sync_q;
  logic                   sclk_dly_q, cs_dly_q;

  logic        dout_q, dout_d;
  logic [23:0] rx_frame_q, rx_frame_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [15:0] dac_q, dac_d;
  logic [10:0] ctrl_q, ctrl_d;
  logic [15:0] input_q, input_d;
  logic [23:0] rx_shift_q, rx_shift_d;
  logic [23:0] tx_shift_q, tx_shift_d;
  logic [23:0] tx_word_q, tx_word_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;

  logic        sclk_s, cs_s, din_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [3:0]  cmd;
  logic [15:0] data;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  // Decode looks at the shift register including any SCLK fall seen this cycle.
  assign cmd  = rx_shift_d[19:16];
  assign data = rx_shift_d[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      din_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b0;
      dout_q      <= 1'b0;
      rx_frame_q  <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      dac_q       <= '0;
      ctrl_q      <= '0;
      input_q     <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_word_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], DAC_SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], DAC_CS_N};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], DAC_DIN};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
      dout_q      <= dout_d;
      rx_frame_q  <= rx_frame_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      dac_q       <= dac_d;
      ctrl_q      <= ctrl_d;
      input_q     <= input_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_word_q   <= tx_word_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    rx_frame_d = rx_frame_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    dac_d      = dac_q;
    ctrl_d     = ctrl_q;
    input_d    = input_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_word_d  = tx_word_q;
    bit_cnt_d  = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          tx_shift_d = tx_word_q;
          // A coincident SCLK rise sees the freshly loaded word.
          if (sclk_rise) begin
            dout_d     = tx_word_q[23];
            tx_shift_d = {tx_word_q[22:0], 1'b0};
          end
        end
      end

      ST_SHIFT: begin
        if (sclk_rise) begin
          dout_d     = tx_shift_q[23];
          tx_shift_d = {tx_shift_q[22:0], 1'b0};
        end
        if (sclk_fall) begin
          rx_shift_d = {rx_shift_q[22:0], din_s};
          if (bit_cnt_q != 5'd31) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        if (cs_rise) begin
          state_d = ST_IDLE;
          dout_d  = 1'b0;
          if (bit_cnt_d == 5'(FRAME_BITS)) begin
            valid_d    = 1'b1;
            rx_frame_d = rx_shift_d;
            // Readback words capture register contents before this frame's update.
            case (cmd)
              4'hA:    tx_word_d = {8'h0A, input_q};
              4'hB:    tx_word_d = {8'h0B, dac_q};
              4'hC:    tx_word_d = {8'h0C, 5'b0, ctrl_q};
              default: tx_word_d = '0;
            endcase
            case (cmd)
              4'h1: input_d = data;
              4'h2: dac_d   = input_q;
              4'h3: begin
                input_d = data;
                dac_d   = data;
              end
              4'h4: ctrl_d = data[10:0];
              4'h7: begin
                input_d = '0;
                dac_d   = '0;
              end
              4'hF: begin
                input_d = '0;
                dac_d   = '0;
                ctrl_d  = '0;
              end
              default: ;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign DAC_DOUT    = dout_q;
  assign rx_frame    = rx_frame_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign dac_code    = dac_q;
  assign ctrl_reg    = ctrl_q;
  assign input_reg   = input_q;

endmodule

`default_nettype wire

// File: doc/ad5761_spi_responder.md
Name: ad5761_spi_responder

Overview:
- SPI slave that emulates the AD5761R DAC serial interface. It is the far end of the team's 24-bit DAC SPI master.
- Decodes command frames into an internal input/DAC/control register set and returns readback data on DAC_DOUT in the following frame.
- Used on-chip as a loopback target for the DAC master, and in emulation builds where no physical DAC is fitted.
- All logic runs in the 50MHz system clock domain; SCLK and CS_N are oversampled.

Parameters:
FRAME_BITS, 24, bits per valid frame
SYNC_STAGES, 2, synchronizer flops on DAC_SCLK, DAC_CS_N and DAC_DIN (minimum 2)

Ports:
clk  input  1  50MHz system clock
rst_n  input  1  asynchronous active-low reset
DAC_SCLK  input  1  SPI clock from master; idles low (CPOL=0)
DAC_CS_N  input  1  chip select, active low
DAC_DIN  input  1  serial data from master (SDI), MSB first
DAC_DOUT  output  1  serial data to master (SDO), MSB first
rx_frame  output  24  last complete frame received
frame_valid  output  1  one-clk pulse when a 24-bit frame is accepted
frame_err  output  1  one-clk pulse when CS_N rises with bit count != FRAME_BITS
dac_code  output  16  DAC register, i.e. the "analog output" code
ctrl_reg  output  11  control register
input_reg  output  16  input (holding) register

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n is asynchronous, active-low. Every output and internal register resets to 0: DAC_DOUT, rx_frame, frame_valid, frame_err, dac_code, ctrl_reg, input_reg, the shift registers, the bit counter and the tx word. Asserting rst_n mid-frame aborts the frame with no register update and no pulse.
- Input synchronization: SCLK, CS_N and DIN each pass through SYNC_STAGES flops. Edges are detected on the synchronized SCLK and CS_N against a one-flop-delayed copy.
- States: IDLE and SHIFT.
- IDLE -> SHIFT on synchronized CS_N falling edge:
  - clear bit_cnt (5-bit);
  - load tx_shift with tx_word;
  - DAC_DOUT stays 0 until the first SCLK rise.
- In SHIFT, on a synchronized SCLK rising edge: DAC_DOUT <= tx_shift[23]; tx_shift shifts left one, filling with 0.
- In SHIFT, on a synchronized SCLK falling edge:
  - rx_shift <= {rx_shift[22:0], DIN_sync};
  - bit_cnt increments and saturates at 31.
- SHIFT -> IDLE on synchronized CS_N rising edge:
  - if bit_cnt == FRAME_BITS, the frame is accepted and decoded; otherwise it is discarded, frame_err pulses, and registers and tx_word are unchanged;
  - DAC_DOUT returns to 0.
- Decode timing: frame_valid pulses in the clk cycle after CS_N rise detection. rx_frame, the register updates and tx_word all take their new values in that same cycle.
- Frame format: cmd = frame[19:16], data = frame[15:0]; frame[23:20] is don't-care.
- Command actions:
  - 0x0 NOP, and 0x9: no change.
  - 0x1: input_reg <= data.
  - 0x2: dac_code <= input_reg.
  - 0x3: input_reg <= data and dac_code <= data.
  - 0x4: ctrl_reg <= data[10:0].
  - 0x7: input_reg and dac_code <= 0.
  - 0xF: input_reg, dac_code and ctrl_reg <= 0.
  - 0x5, 0x6, 0x8, 0xD, 0xE: no change, but frame_valid still pulses.
- tx_word for the next frame:
  - cmd 0xA -> {4'h0, 4'hA, input_reg};
  - cmd 0xB -> {4'h0, 4'hB, dac_code};
  - cmd 0xC -> {4'h0, 4'hC, 5'b0, ctrl_reg};
  - any other accepted frame -> 0.
  - Readback values are taken from register contents before that frame's update. Readback commands never modify registers.
- Frames longer than 24 bits, or aborted frames: discarded, frame_err pulses.
- SCLK edges while CS_N is high (IDLE) are ignored.
- Edge coincidences:
  - CS_N rise detected in the same cycle as an SCLK fall: the fall is processed first, i.e. the bit counts.
  - CS_N fall detected in the same cycle as an SCLK rise: load happens first, then the rise shifts out bit 23.
- Timing requirement: SCLK high and low phases must each be at least SYNC_STAGES+2 clk periods. The team's master (500-clk phases) satisfies this.

Test Plan:
- Master sends 0x01ABCD, then 0x020000 -> input_reg=0xABCD after frame 1 with dac_code still 0; dac_code=0xABCD after frame 2; frame_valid pulses twice.
- Master sends 0x031234, then 0x0B0000, then 0x000000 -> the third frame's DOUT, sampled on SCLK falls, equals 0x0B1234; the second frame's DOUT is 0x000000.
- Master sends 0x0407FF, then 0x0C0000, then NOP -> ctrl_reg=0x7FF; NOP-frame DOUT equals 0x0C07FF.
- CS_N raised after 12 SCLK cycles of 0x01FFFF -> frame_err pulse; input_reg unchanged; no frame_valid.
- After 0x035555, send 0x0F0000 -> dac_code, input_reg and ctrl_reg all 0; next frame DOUT = 0.
- rst_n low for 3 clk in mid-frame of 0x01AAAA -> all outputs 0; the next full frame 0x015A5A is accepted normally and sets input_reg=0x5A5A.
